// File: rtl/bcd_to_xs3_fsm.sv
// Serial BCD-to-Excess-3 converter: a fixed 9-cycle frame of 4 receive,
// 1 compute and 4 transmit states, MSB first in both directions.
module bcd_to_xs3_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  output logic       out,
  output logic [3:0] s_xs3_out,
  output logic [3:0] s_bcd_in
);

  typedef enum logic [3:0] {
    RX0  = 4'd0,
    RX1  = 4'd1,
    RX2  = 4'd2,
    RX3  = 4'd3,
    CALC = 4'd4,
    TX0  = 4'd5,
    TX1  = 4'd6,
    TX2  = 4'd7,
    TX3  = 4'd8
  } state_t;

  state_t state_r;
  state_t next_s;

  // State register; reset drops any partial frame and restarts at RX0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RX0;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic: unconditional cyclic walk through the frame
  always_comb begin
    next_s = RX0;
    case (state_r)
      RX0:     next_s = RX1;
      RX1:     next_s = RX2;
      RX2:     next_s = RX3;
      RX3:     next_s = CALC;
      CALC:    next_s = TX0;
      TX0:     next_s = TX1;
      TX1:     next_s = TX2;
      TX2:     next_s = TX3;
      TX3:     next_s = RX0;
      default: next_s = RX0;
    endcase
  end

  // Datapath registers: shift in during RX, convert once in CALC, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      s_bcd_in  <= 4'd0;
      s_xs3_out <= 4'd0;
    end else begin
      case (state_r)
        RX0, RX1, RX2, RX3: s_bcd_in <= {s_bcd_in[2:0], in};
        // Non-BCD digits wrap modulo 16 rather than being flagged
        CALC:               s_xs3_out <= s_bcd_in + 4'd3;
        default: begin
          s_bcd_in  <= s_bcd_in;
          s_xs3_out <= s_xs3_out;
        end
      endcase
    end
  end

  // Serial output decode from the state register; 0 outside transmit states
  always_comb begin
    out = 1'b0;
    case (state_r)
      TX0:     out = s_xs3_out[3];
      TX1:     out = s_xs3_out[2];
      TX2:     out = s_xs3_out[1];
      TX3:     out = s_xs3_out[0];
      default: out = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_bcd_to_xs3_fsm.sv
// Scoreboard bench for bcd_to_xs3_fsm: the stimulus pushes expected frames,
// a monitor tracks the frame position from reset and checks every cycle.
module tb_bcd_to_xs3_fsm;

  logic       clk;
  logic       rst;
  logic       in;
  logic       out;
  logic [3:0] s_xs3_out;
  logic [3:0] s_bcd_in;

  typedef struct packed {
    logic [3:0] bcd;
    logic [3:0] xs3;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  bcd_to_xs3_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .out       (out),
    .s_xs3_out (s_xs3_out),
    .s_bcd_in  (s_bcd_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // One frame of 9 edges; rst_at >= 0 asserts reset on that edge and ends early
  task automatic send_frame(input int digit, input int rst_at);
    exp_t e;
    e.bcd = 4'(digit);
    e.xs3 = 4'((digit + 3) % 16);
    // The monitor pops on entering CALC, so only frames reaching it are queued
    if (rst_at < 0 || rst_at > 3) q.push_back(e);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rst = 1'b0;
      if (i == rst_at) begin
        rst = 1'b1;
        in  = 1'($urandom);
        break;
      end
      if (i < 4) in = 1'((digit >> (3 - i)) % 2);
      else       in = 1'($urandom);
    end
  endtask

  // Monitor: phase = DUT frame position after each edge, derived from reset only
  initial begin
    bit   synced = 1'b0;
    bit   r;
    int   phase = 0;
    exp_t cur = '0;
    logic [3:0] last_xs3 = 4'd0;
    forever begin
      @(posedge clk);
      r = rst;
      #1;
      if (r) begin
        synced   = 1'b1;
        phase    = 0;
        last_xs3 = 4'd0;
        check("rst_bcd", int'(s_bcd_in), 0);
        check("rst_xs3", int'(s_xs3_out), 0);
        check("rst_out", int'(out), 0);
      end else if (synced) begin
        phase = (phase + 1) % 9;
        if (phase == 4) begin
          if (q.size() == 0) begin
            check("queue_underflow", 0, 1);
          end else begin
            cur = q.pop_front();
            check("rx_bcd", int'(s_bcd_in), int'(cur.bcd));
            check("calc_out", int'(out), 0);
            check("rx_xs3_hold", int'(s_xs3_out), int'(last_xs3));
          end
        end else if (phase >= 5) begin
          last_xs3 = cur.xs3;
          check("tx_bcd_hold", int'(s_bcd_in), int'(cur.bcd));
          check("tx_xs3", int'(s_xs3_out), int'(cur.xs3));
          check("tx_out", int'(out), (int'(cur.xs3) >> (8 - phase)) % 2);
        end else begin
          check("rx_out", int'(out), 0);
          check("rx_xs3_hold", int'(s_xs3_out), int'(last_xs3));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    in  = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b1;
    send_frame(1, -1);
    send_frame(9, -1);
    send_frame(0, -1);
    send_frame(7, 6);
    send_frame(5, -1);
    send_frame(15, -1);
    send_frame(13, -1);
    send_frame(3, 2);
    send_frame(8, -1);
    send_frame(6, 4);
    for (int n = 0; n < 25; n++) send_frame(int'($urandom_range(0, 15)), -1);
    @(negedge clk);
    rst = 1'b0;
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
